// File: rtl/if_stage_if.sv
// if_stage_if: instruction-fetch stage bus (pipeline controls, imem handshake, IF/ID outputs).
interface if_stage_if;
    logic        stall;
    logic        loadForwardStall;
    logic        Br_taken;
    logic [31:0] Br_Addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        fetch_valid;
    modport master (
        input  stall, loadForwardStall, Br_taken, Br_Addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, Instruction, PC, fetch_valid
    );
    modport slave (
        output stall, loadForwardStall, Br_taken, Br_Addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, Instruction, PC, fetch_valid
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with variable-latency imem handshake, stall hold and branch redirect.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, DRAIN} state_t;
    state_t      r_state;
    logic [31:0] r_pc, r_instr, r_br_target;
    logic        w_advance, w_valid;
    logic [31:0] w_br_addr, w_pc_inc;
    assign w_advance = ~bus.stall & ~bus.loadForwardStall;
    assign w_br_addr = bus.Br_Addr & 32'hFFFF_FFFC;
    assign w_pc_inc  = r_pc + 32'd4;
    // A redirect in the same cycle kills whatever instruction would be presented.
    assign w_valid = ~bus.Br_taken & ((r_state == REQ && bus.imem_ack) || r_state == VALID);
    assign bus.imem_req    = (r_state == REQ) || (r_state == DRAIN);
    assign bus.imem_addr   = r_pc;
    assign bus.fetch_valid = w_valid;
    assign bus.Instruction = !w_valid ? 32'd0 : (r_state == VALID) ? r_instr : bus.imem_rdata;
    assign bus.PC          = w_valid ? w_pc_inc : 32'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= 32'd0;
            r_instr     <= 32'd0;
            r_br_target <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    if (bus.Br_taken) r_pc <= w_br_addr;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        if (bus.Br_taken) r_pc <= w_br_addr;
                        else if (w_advance) r_pc <= w_pc_inc;
                        else begin
                            r_instr <= bus.imem_rdata;
                            r_state <= VALID;
                        end
                    end else if (bus.Br_taken) begin
                        r_br_target <= w_br_addr;
                        r_state     <= DRAIN;
                    end
                end
                // Request at the old pc is still outstanding; wait it out, then jump.
                DRAIN: begin
                    if (bus.imem_ack) begin
                        r_pc    <= bus.Br_taken ? w_br_addr : r_br_target;
                        r_state <= REQ;
                    end else if (bus.Br_taken) r_br_target <= w_br_addr;
                end
                VALID: begin
                    if (bus.Br_taken) begin
                        r_pc    <= w_br_addr;
                        r_state <= REQ;
                    end else if (w_advance) begin
                        r_pc    <= w_pc_inc;
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port stall  in  1  hazard-unit hold; fetch must not advance.
REQ-004 SHALL have port loadForwardStall  in  1  load-use hold; same effect as stall.
REQ-005 SHALL have port Br_taken  in  1  branch/jump resolved taken; redirect fetch.
REQ-006 SHALL have port Br_Addr  in  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-007 SHALL have port imem_req  out  1  instruction memory request.
REQ-008 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-009 SHALL have port imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-010 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-011 SHALL have port Instruction  out  32  instruction to IF/ID register; 0 (NOP) when not valid.
REQ-012 SHALL have port PC  out  32  fetch address + 4 for the presented instruction; 0 when not valid.
REQ-013 SHALL have port fetch_valid  out  1  Instruction/PC carry a real instruction this cycle.

Function
REQ-014 SHALL hold internal pc_q (32 bit), instr_q (32 bit), br_target (32 bit), state in {IDLE, REQ, VALID, DRAIN}.
REQ-015 SHALL define advance = ~stall & ~loadForwardStall.
REQ-016 IDLE: imem_req=0, fetch_valid=0; SHALL go to REQ next cycle.
REQ-017 REQ: imem_req=1, imem_addr=pc_q; imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-018 REQ, imem_ack=1, Br_taken=0: Instruction=imem_rdata, PC=pc_q+4, fetch_valid=1 combinationally; if advance, pc_q<=pc_q+4, stay REQ; else instr_q<=imem_rdata, go VALID.
REQ-019 REQ, Br_taken=1, imem_ack=1: data discarded, fetch_valid=0, pc_q<=Br_Addr, stay REQ.
REQ-020 REQ, Br_taken=1, imem_ack=0: br_target<=Br_Addr, go DRAIN, fetch_valid=0.
REQ-021 DRAIN: imem_req=1 at old pc_q, fetch_valid=0; on imem_ack, data discarded, pc_q<=br_target, go REQ; Br_taken in DRAIN SHALL overwrite br_target (latest wins; if same cycle as ack, Br_Addr used directly).
REQ-022 VALID: imem_req=0, Instruction=instr_q, PC=pc_q+4, fetch_valid=1; if Br_taken, pc_q<=Br_Addr, go REQ, fetch_valid=0 (redirect overrides stall); elif advance, pc_q<=pc_q+4, go REQ; else hold.
REQ-023 Br_taken SHALL take priority over stall/loadForwardStall in every state.
REQ-024 PC arithmetic SHALL be modulo 2^32: pc_q=0xFFFFFFFC advancing gives 0x00000000.
REQ-025 Throughput SHALL be one instruction per cycle when imem_ack is returned in the request cycle and advance=1.
REQ-026 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-027 On rst: state<=IDLE, pc_q<=0, instr_q<=0, br_target<=0; imem_req=0, Instruction=0, PC=0, fetch_valid=0 in the following cycle.
REQ-028 rst SHALL override all other inputs; an outstanding request SHALL be abandoned and a later stray imem_ack ignored.

Verification
REQ-029 Reset, zero-wait memory (ack=req), advance=1 -> imem_addr 0,4,8,12 on consecutive cycles from cycle 2; PC outputs 4,8,12,16.
REQ-030 Ack delayed 3 cycles at pc_q=0x10 -> imem_addr=0x10 held 3 cycles, fetch_valid=0, Instruction=0 until ack cycle, then PC=0x14.
REQ-031 stall=1 for 2 cycles at ack of 0x20 -> VALID holds Instruction=rdata, PC=0x24 for 2 cycles, no imem_req; next fetch 0x24 after release.
REQ-032 Br_taken=1, Br_Addr=0x103 during wait at 0x40 -> 0x40 held until ack, data discarded, next imem_addr=0x100.
REQ-033 Br_taken with stall=1 in VALID -> redirect taken next cycle, fetch_valid=0, imem_addr=Br_Addr.
REQ-034 pc_q=0xFFFFFFFC advancing -> next imem_addr=0x00000000; rst mid-wait -> imem_req=0 next cycle, restart at 0.
